// File: rtl/demux_arr_seq_if.sv
// Handshake/bus bundle for demux_arr_seq_module.
// Optional parity port pair is present only when DEMUX_PARITY_EN is defined.
interface demux_arr_seq_if #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [WIDTH-1:0]                 in_data;
  logic                             in_last;
  logic                             frame_ack;
  logic [CHANNELS-1:0][WIDTH-1:0]   out_data;
  logic [CHANNELS-1:0]              out_valid;
  logic                             frame_done;
  logic [SEL_W-1:0]                 sel;
`ifdef DEMUX_PARITY_EN
  logic                             in_par;
  logic                             par_err;
`endif

  modport master (
    output in_valid, in_data, in_last, frame_ack,
`ifdef DEMUX_PARITY_EN
    output in_par,
    input  par_err,
`endif
    input  in_ready, out_data, out_valid, frame_done, sel
  );

  modport slave (
    input  in_valid, in_data, in_last, frame_ack,
`ifdef DEMUX_PARITY_EN
    input  in_par,
    output par_err,
`endif
    output in_ready, out_data, out_valid, frame_done, sel
  );
endinterface

// File: rtl/demux_arr_seq_module.sv
// Sequential 1:N demux: round-robin words into registered lanes, hold frame until acked.
// Optional feature: define DEMUX_PARITY_EN to drop words failing even parity and flag par_err.
module demux_arr_seq_module #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4
) (
  input  logic             clk,
  input  logic             rst,
  demux_arr_seq_if.slave   bus
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e                         state_q, state_d;
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [CHANNELS-1:0][WIDTH-1:0] out_data_q, out_data_d;
  logic [CHANNELS-1:0]            out_valid_q, out_valid_d;
  logic                           frame_done_q, frame_done_d;
  logic                           in_ready_c;
  logic                           accept_c;
  logic                           par_ok_c;
  logic                           sel_last_c;
`ifdef DEMUX_PARITY_EN
  logic                           par_err_q, par_err_d;
`endif

  assign in_ready_c = (state_q == S_FILL);
  assign accept_c   = bus.in_valid & in_ready_c;
  assign sel_last_c = (sel_q == SEL_W'(CHANNELS - 1));

`ifdef DEMUX_PARITY_EN
  assign par_ok_c = ~(^{bus.in_data, bus.in_par});
`else
  assign par_ok_c = 1'b1;
`endif

  // Next-state and lane update
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_err_d    = 1'b0;
`endif
    case (state_q)
      S_FILL: begin
        if (accept_c) begin
          if (!par_ok_c) begin
`ifdef DEMUX_PARITY_EN
            par_err_d = 1'b1;
`endif
          end else begin
            out_data_d[sel_q]  = bus.in_data;
            out_valid_d[sel_q] = 1'b1;
            if (sel_last_c || bus.in_last) begin
              state_d      = S_HOLD;
              frame_done_d = 1'b1;
              sel_d        = '0;
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end
        end
      end
      S_HOLD: begin
        if (bus.frame_ack) begin
          out_valid_d = '0;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      sel_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sel        = sel_q;
endmodule

// File: tb/tb_demux_arr_seq_module.sv
// Directed self-checking bench for demux_arr_seq_module (WIDTH=2, CHANNELS=4).
// Parity steps run only when DEMUX_PARITY_EN is defined.
module tb_demux_arr_seq_module;
  logic clk;
  logic rst;
  int   total;
  int   passed;

  demux_arr_seq_if #(.WIDTH(2), .CHANNELS(4)) bus ();

  demux_arr_seq_module #(.WIDTH(2), .CHANNELS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.frame_ack = 1'b0;
`ifdef DEMUX_PARITY_EN
    bus.in_par    = 1'b0;
`endif

    // Async reset with no clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_out_data",   32'(bus.out_data),   32'h00);
    chk("rst_out_valid",  32'(bus.out_valid),  32'h0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    chk("rst_sel",        32'(bus.sel),        32'h0);
    #8 rst = 1'b0;
    #1;
    chk("rst_in_ready",   32'(bus.in_ready),   32'h1);

    // Full frame 11,10,01,00
    tick();
    bus.in_valid = 1'b1; bus.in_data = 2'b11;
    tick();
    chk("full_sel1",       32'(bus.sel),       32'h1);
    chk("full_valid1",     32'(bus.out_valid), 32'h1);
    chk("full_lane0",      32'(bus.out_data),  32'h03);
    bus.in_data = 2'b10; tick();
    bus.in_data = 2'b01; tick();
    chk("full_done_early", 32'(bus.frame_done), 32'h0);
    bus.in_data = 2'b00; tick();
    chk("full_data",       32'(bus.out_data),   32'h1B);
    chk("full_valid",      32'(bus.out_valid),  32'hF);
    chk("full_done",       32'(bus.frame_done), 32'h1);
    chk("full_sel0",       32'(bus.sel),        32'h0);
    chk("full_ready",      32'(bus.in_ready),   32'h0);

    // Backpressure in HOLD
    bus.in_data = 2'b01;
    tick();
    chk("hold_done_pulse", 32'(bus.frame_done), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data",  32'(bus.out_data),  32'h1B);
      chk("hold_valid", 32'(bus.out_valid), 32'hF);
      chk("hold_ready", 32'(bus.in_ready),  32'h0);
    end
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("ack_valid", 32'(bus.out_valid), 32'h0);
    chk("ack_data",  32'(bus.out_data),  32'h1B);
    chk("ack_ready", 32'(bus.in_ready),  32'h1);
    chk("ack_sel",   32'(bus.sel),       32'h0);
    tick();
    chk("held_word_data",  32'(bus.out_data),  32'h19);
    chk("held_word_valid", 32'(bus.out_valid), 32'h1);
    chk("held_word_sel",   32'(bus.sel),       32'h1);

    // Early close: second word of the frame carries in_last
    bus.in_data = 2'b11; bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("early_valid", 32'(bus.out_valid),  32'h3);
    chk("early_data",  32'(bus.out_data),   32'h1D);
    chk("early_done",  32'(bus.frame_done), 32'h1);
    chk("early_sel",   32'(bus.sel),        32'h0);
    chk("early_ready", 32'(bus.in_ready),   32'h0);
    tick();
    chk("early_done_off", 32'(bus.frame_done), 32'h0);

    // Release, then ack in FILL is ignored
    bus.frame_ack = 1'b1;
    tick();
    chk("rel_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("fill_ack_ready", 32'(bus.in_ready),  32'h1);
    chk("fill_ack_valid", 32'(bus.out_valid), 32'h0);

    // Ack together with closing accept is ignored
    bus.in_valid = 1'b1; bus.in_data = 2'b10; bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.frame_ack = 1'b0;
    chk("same_ack_done",  32'(bus.frame_done), 32'h1);
    chk("same_ack_valid", 32'(bus.out_valid),  32'h1);
    chk("same_ack_data",  32'(bus.out_data),   32'h1E);
    tick();
    tick();
    chk("same_ack_still_hold",  32'(bus.in_ready),  32'h0);
    chk("same_ack_valid_kept",  32'(bus.out_valid), 32'h1);
    bus.frame_ack = 1'b1;
    tick();
    chk("late_ack_ready", 32'(bus.in_ready),  32'h1);
    chk("late_ack_valid", 32'(bus.out_valid), 32'h0);

    // Accept while frame_ack is high in FILL keeps the lane valid
    bus.in_valid = 1'b1; bus.in_data = 2'b01;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.frame_ack = 1'b0;
    chk("fill_ack_accept_valid", 32'(bus.out_valid), 32'h1);
    chk("fill_ack_accept_sel",   32'(bus.sel),       32'h1);

    // Reset mid-frame discards the partial frame immediately
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_data",  32'(bus.out_data),  32'h00);
    chk("midrst_sel",   32'(bus.sel),       32'h0);
    #1 rst = 1'b0;
    tick();
    chk("midrst_ready", 32'(bus.in_ready),  32'h1);

`ifdef DEMUX_PARITY_EN
    // Bad parity word dropped, good one written
    bus.in_valid = 1'b1; bus.in_data = 2'b01; bus.in_par = 1'b0; bus.in_last = 1'b1;
    tick();
    chk("par_err_pulse", 32'(bus.par_err),    32'h1);
    chk("par_sel",       32'(bus.sel),        32'h0);
    chk("par_valid",     32'(bus.out_valid),  32'h0);
    chk("par_no_close",  32'(bus.frame_done), 32'h0);
    bus.in_par = 1'b1; bus.in_last = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("par_err_clear", 32'(bus.par_err),   32'h0);
    chk("par_good_valid", 32'(bus.out_valid), 32'h1);
    chk("par_good_data",  32'(bus.out_data),  32'h01);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
